// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Two-requester writeback arbiter for the register-file write port.
//   Requester 0 is the ALU writeback and requester 1 is the load writeback.
//   A lone requester is always granted in its own cycle. When both request,
//   a two-state round-robin FSM picks the winner; the winner's address and
//   data are registered, so the register file sees them one cycle later,
//   stable across the falling edge on which it commits.
//
//   Optional feature macro: ZERO_REG_PROTECT_EN
//     defined   : a transfer to register 0 is granted and consumed, but it
//                 produces RegWrite = 0 on the following cycle.
//     undefined : register 0 is written like any other register.
//
// Parameters
//   CNT_W        width of the saturating conflict counter (default 16)
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous, active-high reset
//   req0/addr0/data0, gnt0   requester 0 handshake (transfer = req0 & gnt0)
//   req1/addr1/data1, gnt1   requester 1 handshake (transfer = req1 & gnt1)
//   RegWrite     register-file write enable (registered)
//   inC          register-file write address (registered)
//   out          register-file write data (registered)
//   conflict_cnt saturating count of cycles with both requests pending
module regfile_wb_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [4:0]       addr0,
  input  logic [31:0]      data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [4:0]       addr1,
  input  logic [31:0]      data1,
  output logic             gnt1,
  output logic             RegWrite,
  output logic [4:0]       inC,
  output logic [31:0]      out,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {
    PRIO0 = 1'b0,
    PRIO1 = 1'b1
  } prio_t;

  prio_t prio;

  logic        xfer;
  logic [4:0]  win_addr;
  logic [31:0] win_data;
  logic        win_we;
  logic        both_req;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Grants are combinational; rst forces both low so no transfer can be
  // accepted while the block is being reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        gnt0 = (prio == PRIO0);
        gnt1 = (prio == PRIO1);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    xfer     = gnt0 | gnt1;
    win_addr = gnt1 ? addr1 : addr0;
    win_data = gnt1 ? data1 : data0;
    both_req = req0 & req1;
`ifdef ZERO_REG_PROTECT_EN
    win_we   = xfer & (win_addr != 5'd0);
`else
    win_we   = xfer;
`endif
  end

  // Stage boundary: arbitration result registered onto the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio         <= PRIO0;
      RegWrite     <= 1'b0;
      inC          <= 5'd0;
      out          <= 32'd0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0) begin
        prio <= PRIO1;
      end else if (gnt1) begin
        prio <= PRIO0;
      end

      RegWrite <= win_we;
      if (xfer) begin
        inC <= win_addr;
        out <= win_data;
      end

      if (both_req) begin
        conflict_cnt <= sat_inc(conflict_cnt);
      end
    end
  end

endmodule
